// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline hold/flush sequencer resolving load-use, branch and memory-wait hazards,
// with a sticky wait-timeout flag and saturating stall/flush counters.
module hazard_control_unit #(
    parameter int CNT_WIDTH    = 32,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [4:0]           RS1_D,
    input  logic [4:0]           RS2_D,
    input  logic [4:0]           RD_E,
    input  logic                 Mem_Read_E,
    input  logic                 Branch_Taken_E,
    input  logic                 IMem_Ready,
    input  logic                 DMem_Req_M,
    input  logic                 DMem_Ready,
    output logic                 Stall_F,
    output logic                 Stall_En,
    output logic                 Flush_D,
    output logic                 Flush_E,
    output logic                 Freeze,
    output logic                 Mem_Timeout,
    output logic [CNT_WIDTH-1:0] Stall_Cycles,
    output logic [CNT_WIDTH-1:0] Flush_Count
);
    typedef enum logic [1:0] {START, RUN, IMEM_WAIT, DMEM_WAIT} state_t;
    state_t state, state_nx;
    logic flush_pending, dmem_wait, load_use, waiting;
    logic [7:0] wait_cnt;
    logic [8:0] wait_inc;
    assign dmem_wait = DMem_Req_M & ~DMem_Ready;
    assign load_use  = Mem_Read_E & (RD_E != 5'd0) & ((RD_E == RS1_D) | (RD_E == RS2_D));
    assign waiting   = (state_nx == IMEM_WAIT) | (state_nx == DMEM_WAIT);
    assign wait_inc  = {1'b0, wait_cnt} + 9'd1;
    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= START;
        else state <= state_nx;
    always_comb
        state_nx = (state == START) ? RUN : dmem_wait ? DMEM_WAIT : !IMem_Ready ? IMEM_WAIT : RUN;
    // A pending flush kills the wrong-path fetch on its ready cycle, ahead of any load-use stall.
    always_comb begin
        {Stall_F, Stall_En, Flush_D, Flush_E, Freeze} = 5'b0;
        if (state == START) {Stall_F, Flush_D, Flush_E} = 3'b111;
        else if (dmem_wait) {Stall_F, Stall_En, Freeze} = 3'b111;
        else if (Branch_Taken_E) {Flush_D, Flush_E} = 2'b11;
        else if (flush_pending & IMem_Ready) Flush_D = 1'b1;
        else if (load_use) {Stall_F, Stall_En, Flush_E} = 3'b111;
        else if (!IMem_Ready) {Stall_F, Flush_D} = 2'b11;
    end
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            flush_pending <= 1'b0;
            wait_cnt      <= 8'd0;
            Mem_Timeout   <= 1'b0;
            Stall_Cycles  <= '0;
            Flush_Count   <= '0;
        end else begin
            if (!dmem_wait)
                flush_pending <= IMem_Ready ? 1'b0 : flush_pending | (Branch_Taken_E & (state == IMEM_WAIT));
            wait_cnt <= !waiting ? 8'd0 : wait_inc[8] ? wait_cnt : wait_inc[7:0];
            if (waiting && wait_inc >= 9'(WAIT_TIMEOUT)) Mem_Timeout <= 1'b1;
            if (Stall_En && !(&Stall_Cycles)) Stall_Cycles <= Stall_Cycles + CNT_WIDTH'(1);
            if (Flush_D && !(&Flush_Count)) Flush_Count <= Flush_Count + CNT_WIDTH'(1);
        end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and randomized checks of the hazard sequencer against a
// cycle-level behavioural model of the hazard rules.
module tb_hazard_control_unit;
    localparam int CW = 8;
    localparam int TO = 4;
    logic CLK = 1'b0, RST = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic mr = 1'b0, bt = 1'b0, ir = 1'b1, dq = 1'b0, dr = 1'b1;
    logic Stall_F, Stall_En, Flush_D, Flush_E, Freeze, Mem_Timeout;
    logic [CW-1:0] Stall_Cycles, Flush_Count;
    logic [5:0] act_out, exp_out;
    int vectors = 0, errors = 0;
    bit m_start, m_imw, m_pend, m_to;
    int m_wait, m_stall, m_flush;

    hazard_control_unit #(.CNT_WIDTH(CW), .WAIT_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .RS1_D(rs1), .RS2_D(rs2), .RD_E(rd),
        .Mem_Read_E(mr), .Branch_Taken_E(bt), .IMem_Ready(ir), .DMem_Req_M(dq), .DMem_Ready(dr),
        .Stall_F(Stall_F), .Stall_En(Stall_En), .Flush_D(Flush_D), .Flush_E(Flush_E),
        .Freeze(Freeze), .Mem_Timeout(Mem_Timeout), .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
    );
    assign act_out = {Stall_F, Stall_En, Flush_D, Flush_E, Freeze, Mem_Timeout};
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_start = 1; m_imw = 0; m_pend = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endtask

    // Expected controls as {Stall_F, Stall_En, Flush_D, Flush_E, Freeze, Mem_Timeout}
    task automatic model_eval();
        bit fr, lu;
        fr = dq && !dr;
        lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
        if (m_start) exp_out = 6'b101100;
        else if (fr) exp_out = 6'b110010;
        else if (bt) exp_out = 6'b001100;
        else if (m_pend && ir) exp_out = 6'b001000;
        else if (lu) exp_out = 6'b110100;
        else if (!ir) exp_out = 6'b101000;
        else exp_out = 6'b000000;
        exp_out[0] = m_to;
    endtask

    task automatic model_step();
        bit fr, wt;
        model_eval();
        fr = dq && !dr;
        wt = !m_start && (fr || !ir);
        if (exp_out[4]) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
        if (exp_out[3]) m_flush = (m_flush < 255) ? m_flush + 1 : 255;
        if (!fr) m_pend = ir ? 0 : (m_pend || (bt && m_imw));
        if (wt && m_wait + 1 >= TO) m_to = 1;
        m_wait = wt ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
        m_imw = !m_start && !fr && !ir;
        m_start = 0;
    endtask

    task automatic drive(input logic [4:0] a, b, d, input logic m, br, i, q, r);
        rs1 = a; rs2 = b; rd = d; mr = m; bt = br; ir = i; dq = q; dr = r;
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 0; model_reset();
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        RST = 1;
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        RST = 0; model_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 1);
            vectors++;
            if (act_out !== exp_out) begin errors++; $display("FAIL reset_hold: got %b want %b", act_out, exp_out); end
            vectors++;
            if (Stall_Cycles !== 0 || Flush_Count !== 0) begin
                errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", Stall_Cycles, Flush_Count);
            end
            tick();
        end
        RST = 1;
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b101100) begin errors++; $display("FAIL start_cycle: got %b want 101100", act_out); end
        vectors++;
        if (Stall_Cycles !== 0 || Flush_Count !== 0) begin
            errors++; $display("FAIL start_counters: got %0d/%0d want 0/0", Stall_Cycles, Flush_Count);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b000000) begin errors++; $display("FAIL after_start: got %b want 000000", act_out); end
        vectors++;
        if (Flush_Count !== 8'd1) begin errors++; $display("FAIL start_flush_count: got %0d want 1", Flush_Count); end
        tick();
    endtask

    task automatic test_load_use();
        drive(0, 5, 5, 1, 0, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b110100) begin errors++; $display("FAIL load_use: got %b want 110100", act_out); end
        tick();
        drive(0, 0, 0, 1, 0, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b000000) begin errors++; $display("FAIL load_use_x0: got %b want 000000", act_out); end
        vectors++;
        if (Stall_Cycles !== 8'd1) begin errors++; $display("FAIL load_use_count: got %0d want 1", Stall_Cycles); end
        tick();
    endtask

    task automatic test_branch_load_use();
        drive(7, 0, 7, 1, 1, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b001100) begin errors++; $display("FAIL branch_over_lu: got %b want 001100", act_out); end
        tick();
    endtask

    task automatic test_dmem_wait();
        int frozen;
        frozen = 0;
        for (int k = 1; k <= 4; k++) begin
            drive(3, 3, 3, 1, k == 2, 1, 1, 0);
            vectors++;
            if (act_out !== exp_out) begin errors++; $display("FAIL dmem_wait%0d: got %b want %b", k, act_out, exp_out); end
            if (Freeze && Stall_En && Stall_F && !Flush_D && !Flush_E) frozen++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1, 1);
        vectors++;
        if (Freeze !== 1'b0) begin errors++; $display("FAIL dmem_ready_freeze: got %b want 0", Freeze); end
        vectors++;
        if (frozen !== 4) begin errors++; $display("FAIL dmem_frozen_cycles: got %0d want 4", frozen); end
        tick();
    endtask

    task automatic test_imem_branch();
        logic [4:0] want [4];
        want = '{5'b10100, 5'b00110, 5'b10100, 5'b00100};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, k == 1, k == 3, 0, 1);
            vectors++;
            if (act_out[5:1] !== want[k]) begin
                errors++; $display("FAIL imem_branch%0d: got %b want %b", k + 1, act_out[5:1], want[k]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b000000) begin errors++; $display("FAIL imem_pending_clear: got %b want 000000", act_out); end
        vectors++;
        if (Flush_Count !== 8'd5) begin errors++; $display("FAIL imem_flush_count: got %0d want 5", Flush_Count); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            vectors++;
            if (Mem_Timeout !== (k >= 5)) begin
                errors++; $display("FAIL timeout_c%0d: got %b want %b", k, Mem_Timeout, k >= 5);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 1);
            vectors++;
            if (Mem_Timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", Mem_Timeout); end
            tick();
        end
        RST = 0; model_reset();
        #1;
        vectors++;
        if (Mem_Timeout !== 1'b0) begin errors++; $display("FAIL timeout_async_clear: got %b want 0", Mem_Timeout); end
        tick();
        RST = 1;
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        tick();
        RST = 0; model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (act_out !== 6'b101100) begin errors++; $display("FAIL reset_mid_wait: got %b want 101100", act_out); end
        tick();
        RST = 1;
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (act_out !== 6'b000000) begin errors++; $display("FAIL pending_discarded: got %b want 000000", act_out); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 300; k++) begin drive(0, 0, 0, 0, 0, 0, 0, 1); tick(); end
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (Flush_Count !== 8'(m_flush) || Flush_Count !== 8'hFF) begin
            errors++; $display("FAIL flush_saturate: got %0d want 255", Flush_Count);
        end
        tick();
        for (int k = 0; k < 300; k++) begin drive(0, 0, 0, 0, 0, 1, 1, 0); tick(); end
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (Stall_Cycles !== 8'(m_stall) || Stall_Cycles !== 8'hFF) begin
            errors++; $display("FAIL stall_saturate: got %0d want 255", Stall_Cycles);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                RST = 0; model_reset();
                drive(0, 0, 0, 0, 0, 1, 0, 1);
                tick();
                RST = 1;
            end
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
            vectors++;
            if (act_out !== exp_out) begin errors++; $display("FAIL rand_ctl@%0d: got %b want %b", k, act_out, exp_out); end
            vectors++;
            if (Stall_Cycles !== 8'(m_stall) || Flush_Count !== 8'(m_flush)) begin
                errors++;
                $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", k, Stall_Cycles, Flush_Count, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_dmem_wait();
        test_imem_branch();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
